// File: rtl/motion_sequencer_if.sv
// Command handshake between robot-level command logic and the motion sequencer.
// A command transfers on a clock edge where cmd_valid and cmd_ready are both high.
interface motion_sequencer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_speed;
  logic [15:0] cmd_ticks;
  logic        cmd_dir;

  modport master (output cmd_valid, cmd_speed, cmd_ticks, cmd_dir, input cmd_ready);
  modport slave  (input cmd_valid, cmd_speed, cmd_ticks, cmd_dir, output cmd_ready);
endinterface

// File: rtl/motion_sequencer.sv
// Sequences one wheel's speed loop through ramp-up, cruise and ramp-down for a
// single move command, counting synchronised encoder edges until the distance is covered.
module motion_sequencer #(
  parameter int RAMP_DIV   = 2000000,
  parameter int RAMP_STEP  = 90,
  parameter int MIN_DEG    = 90,
  parameter int MAX_DEG    = 1440,
  parameter int SLOW_TICKS = 64,
  parameter int SETTLE     = 1600000
) (
  input  logic                clk,
  input  logic                reset,
  motion_sequencer_if.slave   cmd,
  input  logic                abort,
  input  logic                encoder,
  output logic [15:0]         deg_s,
  output logic                motor_en,
  output logic                dir,
  output logic                busy,
  output logic                done,
  output logic                aborted,
  output logic [2:0]          o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RAMP_UP   = 3'd1,
    S_CRUISE    = 3'd2,
    S_RAMP_DOWN = 3'd3,
    S_SETTLE    = 3'd4
  } state_t;

  localparam logic [15:0] P_STEP          = 16'(RAMP_STEP);
  localparam logic [15:0] P_MIN           = 16'(MIN_DEG);
  localparam logic [15:0] P_MAX           = 16'(MAX_DEG);
  localparam logic [15:0] P_SLOW          = 16'(SLOW_TICKS);
  localparam logic [31:0] P_RAMP_RELOAD   = 32'(RAMP_DIV - 1);
  localparam logic [31:0] P_SETTLE_RELOAD = 32'(SETTLE - 1);

  state_t      r_state;
  logic [2:0]  r_enc_sync;
  logic [15:0] r_count;
  logic [15:0] r_ticks;
  logic [15:0] r_target;
  logic [15:0] r_deg;
  logic [31:0] r_ramp_tmr;
  logic [31:0] r_settle_tmr;
  logic        r_motor_en;
  logic        r_dir;
  logic        r_done;
  logic        r_aborted;

  logic        w_enc_rise;
  logic [15:0] w_count_nxt;
  logic [15:0] w_cmd_target;
  logic [15:0] w_floor;
  logic [16:0] w_up_sum;
  logic [15:0] w_up_val;
  logic [15:0] w_dn_val;
  logic        w_reached;
  logic        w_slow;
  logic        w_accept;

  assign w_enc_rise   = r_enc_sync[1] & ~r_enc_sync[2];
  // Tick edge landing on the same cycle as the distance compare is counted first.
  assign w_count_nxt  = (r_state != S_IDLE && w_enc_rise && r_count != 16'hFFFF)
                        ? r_count + 16'd1 : r_count;
  assign w_cmd_target = (cmd.cmd_speed > P_MAX) ? P_MAX : cmd.cmd_speed;
  assign w_floor      = (r_target < P_MIN) ? r_target : P_MIN;
  assign w_up_sum     = {1'b0, r_deg} + {1'b0, P_STEP};
  assign w_up_val     = (w_up_sum >= {1'b0, r_target}) ? r_target : w_up_sum[15:0];
  assign w_dn_val     = ({1'b0, r_deg} >= ({1'b0, w_floor} + {1'b0, P_STEP}))
                        ? r_deg - P_STEP : w_floor;
  assign w_reached    = (w_count_nxt >= r_ticks);
  assign w_slow       = ((r_ticks - w_count_nxt) <= P_SLOW);
  assign w_accept     = cmd.cmd_valid && (r_state == S_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_enc_sync   <= 3'b000;
      r_count      <= 16'd0;
      r_ticks      <= 16'd0;
      r_target     <= 16'd0;
      r_deg        <= 16'd0;
      r_ramp_tmr   <= 32'd0;
      r_settle_tmr <= 32'd0;
      r_motor_en   <= 1'b0;
      r_dir        <= 1'b0;
      r_done       <= 1'b0;
      r_aborted    <= 1'b0;
    end else begin
      r_enc_sync <= {r_enc_sync[1:0], encoder};
      r_done     <= 1'b0;
      r_count    <= w_count_nxt;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_target  <= w_cmd_target;
            r_ticks   <= cmd.cmd_ticks;
            r_dir     <= cmd.cmd_dir;
            r_count   <= 16'd0;
            r_aborted <= 1'b0;
            if (cmd.cmd_ticks == 16'd0 || w_cmd_target == 16'd0) begin
              r_state      <= S_SETTLE;
              r_settle_tmr <= P_SETTLE_RELOAD;
              r_deg        <= 16'd0;
              r_motor_en   <= 1'b0;
            end else begin
              r_state    <= S_RAMP_UP;
              r_deg      <= (w_cmd_target < P_STEP) ? w_cmd_target : P_STEP;
              r_motor_en <= 1'b1;
              r_ramp_tmr <= P_RAMP_RELOAD;
            end
          end
        end
        S_RAMP_UP, S_CRUISE, S_RAMP_DOWN: begin
          if (abort || w_reached) begin
            r_state      <= S_SETTLE;
            r_settle_tmr <= P_SETTLE_RELOAD;
            r_deg        <= 16'd0;
            r_motor_en   <= 1'b0;
            if (abort) r_aborted <= 1'b1;
          end else if (r_state != S_RAMP_DOWN && w_slow) begin
            r_state    <= S_RAMP_DOWN;
            r_ramp_tmr <= P_RAMP_RELOAD;
          end else if (r_state == S_RAMP_UP) begin
            if (r_deg == r_target) begin
              r_state <= S_CRUISE;
            end else if (r_ramp_tmr == 32'd0) begin
              r_deg      <= w_up_val;
              r_ramp_tmr <= P_RAMP_RELOAD;
            end else begin
              r_ramp_tmr <= r_ramp_tmr - 32'd1;
            end
          end else if (r_state == S_CRUISE) begin
            r_deg <= r_target;
          end else begin
            if (r_ramp_tmr == 32'd0) begin
              r_deg      <= w_dn_val;
              r_ramp_tmr <= P_RAMP_RELOAD;
            end else begin
              r_ramp_tmr <= r_ramp_tmr - 32'd1;
            end
          end
        end
        S_SETTLE: begin
          if (r_settle_tmr == 32'd0) begin
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_settle_tmr <= r_settle_tmr - 32'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cmd.cmd_ready = (r_state == S_IDLE);
  assign deg_s         = r_deg;
  assign motor_en      = r_motor_en;
  assign dir           = r_dir;
  assign busy          = (r_state != S_IDLE);
  assign done          = r_done;
  assign aborted       = r_aborted;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_motion_sequencer.sv
// Directed bench for motion_sequencer with shortened ramp/settle timing.
module tb_motion_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        abort = 1'b0;
  logic        encoder = 1'b0;
  logic [15:0] deg_s;
  logic        motor_en;
  logic        dir;
  logic        busy;
  logic        done;
  logic        aborted;
  logic [2:0]  dbg_state;

  int errors = 0;
  int checks = 0;

  motion_sequencer_if cmd_if();

  motion_sequencer #(
    .RAMP_DIV(4), .RAMP_STEP(90), .MIN_DEG(90), .MAX_DEG(1440),
    .SLOW_TICKS(4), .SETTLE(8)
  ) dut (
    .clk(clk), .reset(reset), .cmd(cmd_if), .abort(abort), .encoder(encoder),
    .deg_s(deg_s), .motor_en(motor_en), .dir(dir), .busy(busy), .done(done),
    .aborted(aborted), .o_dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic tick();
    encoder = 1'b1;
    step(2);
    encoder = 1'b0;
    step(2);
  endtask

  task automatic send_cmd(input logic [15:0] spd, input logic [15:0] tks, input logic d);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_speed = spd;
    cmd_if.cmd_ticks = tks;
    cmd_if.cmd_dir   = d;
    step(1);
    cmd_if.cmd_valid = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      step(1);
      n++;
    end while (!done && n < 40);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(2);
    checks++; if (deg_s !== 16'd0) begin errors++; $display("FAIL reset_deg: got %0d expected 0", deg_s); end
    checks++; if (motor_en !== 1'b0) begin errors++; $display("FAIL reset_en: got %b expected 0", motor_en); end
    checks++; if ({dir, busy, done, aborted} !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b expected 0000", {dir, busy, done, aborted}); end
    reset = 1'b0;
    step(1);
    checks++; if (cmd_if.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", cmd_if.cmd_ready); end
  endtask

  task automatic test_profile();
    int n;
    send_cmd(16'd360, 16'd20, 1'b0);
    checks++; if (deg_s !== 16'd90 || motor_en !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL prof_start: deg=%0d en=%b busy=%b expected 90 1 1", deg_s, motor_en, busy); end
    step(3);
    checks++; if (deg_s !== 16'd90) begin errors++; $display("FAIL prof_hold90: got %0d expected 90", deg_s); end
    step(1);
    checks++; if (deg_s !== 16'd180) begin errors++; $display("FAIL prof_180: got %0d expected 180", deg_s); end
    step(4);
    checks++; if (deg_s !== 16'd270) begin errors++; $display("FAIL prof_270: got %0d expected 270", deg_s); end
    step(4);
    checks++; if (deg_s !== 16'd360) begin errors++; $display("FAIL prof_360: got %0d expected 360", deg_s); end
    step(1);
    for (int i = 0; i < 15; i++) tick();
    checks++; if (deg_s !== 16'd360 || motor_en !== 1'b1) begin errors++; $display("FAIL prof_cruise: deg=%0d en=%b expected 360 1", deg_s, motor_en); end
    tick();
    checks++; if (deg_s !== 16'd360) begin errors++; $display("FAIL prof_t16: got %0d expected 360", deg_s); end
    tick();
    checks++; if (deg_s !== 16'd270) begin errors++; $display("FAIL prof_down270: got %0d expected 270", deg_s); end
    tick();
    checks++; if (deg_s !== 16'd180) begin errors++; $display("FAIL prof_down180: got %0d expected 180", deg_s); end
    tick();
    checks++; if (deg_s !== 16'd90) begin errors++; $display("FAIL prof_down90: got %0d expected 90", deg_s); end
    step(8);
    checks++; if (deg_s !== 16'd90 || motor_en !== 1'b1) begin errors++; $display("FAIL prof_floor: deg=%0d en=%b expected 90 1", deg_s, motor_en); end
    tick();
    checks++; if (deg_s !== 16'd0 || motor_en !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL prof_stop: deg=%0d en=%b busy=%b expected 0 0 1", deg_s, motor_en, busy); end
    wait_done(n);
    checks++; if (n !== 7) begin errors++; $display("FAIL prof_done_time: got %0d cycles expected 7", n); end
    checks++; if (aborted !== 1'b0 || busy !== 1'b0 || cmd_if.cmd_ready !== 1'b1) begin errors++; $display("FAIL prof_done_flags: ab=%b busy=%b rdy=%b expected 0 0 1", aborted, busy, cmd_if.cmd_ready); end
    step(1);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL prof_done_pulse: got %b expected 0", done); end
  endtask

  task automatic test_saturation_abort();
    int n;
    logic [15:0] max_deg;
    send_cmd(16'd2000, 16'd200, 1'b1);
    checks++; if (dir !== 1'b1) begin errors++; $display("FAIL sat_dir: got %b expected 1", dir); end
    max_deg = deg_s;
    for (int i = 0; i < 70; i++) begin
      step(1);
      if (deg_s > max_deg) max_deg = deg_s;
    end
    checks++; if (max_deg !== 16'd1440) begin errors++; $display("FAIL sat_max: got %0d expected 1440", max_deg); end
    checks++; if (deg_s !== 16'd1440) begin errors++; $display("FAIL sat_final: got %0d expected 1440", deg_s); end
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    checks++; if (deg_s !== 16'd0 || motor_en !== 1'b0) begin errors++; $display("FAIL abort_stop: deg=%0d en=%b expected 0 0", deg_s, motor_en); end
    wait_done(n);
    checks++; if (n !== 8) begin errors++; $display("FAIL abort_done_time: got %0d cycles expected 8", n); end
    checks++; if (aborted !== 1'b1) begin errors++; $display("FAIL abort_flag: got %b expected 1", aborted); end
    step(3);
    checks++; if (aborted !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL abort_held: ab=%b done=%b expected 1 0", aborted, done); end
  endtask

  task automatic test_zero_length();
    int n;
    int en_seen;
    send_cmd(16'd360, 16'd0, 1'b0);
    checks++; if (motor_en !== 1'b0 || busy !== 1'b1 || aborted !== 1'b0) begin errors++; $display("FAIL zero_start: en=%b busy=%b ab=%b expected 0 1 0", motor_en, busy, aborted); end
    en_seen = 0;
    n = 0;
    do begin
      step(1);
      n++;
      if (motor_en) en_seen++;
    end while (!done && n < 40);
    checks++; if (n !== 8) begin errors++; $display("FAIL zero_done_time: got %0d cycles expected 8", n); end
    checks++; if (en_seen !== 0) begin errors++; $display("FAIL zero_en: got %0d enabled cycles expected 0", en_seen); end
    checks++; if (aborted !== 1'b0) begin errors++; $display("FAIL zero_aborted: got %b expected 0", aborted); end
    step(1);
    send_cmd(16'd0, 16'd50, 1'b0);
    checks++; if (motor_en !== 1'b0 || deg_s !== 16'd0) begin errors++; $display("FAIL zspeed_start: en=%b deg=%0d expected 0 0", motor_en, deg_s); end
    wait_done(n);
    checks++; if (n !== 8) begin errors++; $display("FAIL zspeed_done_time: got %0d cycles expected 8", n); end
  endtask

  task automatic test_low_target();
    int n;
    send_cmd(16'd45, 16'd10, 1'b0);
    checks++; if (deg_s !== 16'd45) begin errors++; $display("FAIL low_start: got %0d expected 45", deg_s); end
    for (int i = 0; i < 6; i++) tick();
    step(12);
    checks++; if (deg_s !== 16'd45 || motor_en !== 1'b1) begin errors++; $display("FAIL low_floor: deg=%0d en=%b expected 45 1", deg_s, motor_en); end
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    wait_done(n);
    checks++; if (n !== 8 || aborted !== 1'b1) begin errors++; $display("FAIL low_abort: cycles=%0d ab=%b expected 8 1", n, aborted); end
    step(1);
  endtask

  task automatic test_back_to_back();
    int n;
    int done_at;
    int ready_busy;
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_speed = 16'd360;
    cmd_if.cmd_ticks = 16'd0;
    cmd_if.cmd_dir   = 1'b0;
    step(1);
    cmd_if.cmd_speed = 16'd180;
    cmd_if.cmd_ticks = 16'd30;
    cmd_if.cmd_dir   = 1'b1;
    n = 0;
    done_at = 0;
    ready_busy = 0;
    do begin
      step(1);
      n++;
      if (done) done_at = n;
      if (busy && cmd_if.cmd_ready) ready_busy++;
    end while (!motor_en && n < 40);
    cmd_if.cmd_valid = 1'b0;
    checks++; if (done_at !== 8) begin errors++; $display("FAIL b2b_done_at: got %0d expected 8", done_at); end
    checks++; if (n !== 9) begin errors++; $display("FAIL b2b_accept_at: got %0d expected 9", n); end
    checks++; if (ready_busy !== 0) begin errors++; $display("FAIL b2b_ready_busy: got %0d expected 0", ready_busy); end
    checks++; if (dir !== 1'b1 || deg_s !== 16'd90) begin errors++; $display("FAIL b2b_second: dir=%b deg=%0d expected 1 90", dir, deg_s); end
  endtask

  task automatic test_reset_mid();
    int done_cnt;
    step(2);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    checks++; if (deg_s !== 16'd0 || motor_en !== 1'b0) begin errors++; $display("FAIL rmid_out: deg=%0d en=%b expected 0 0", deg_s, motor_en); end
    checks++; if ({dir, busy, done, aborted} !== 4'b0000) begin errors++; $display("FAIL rmid_flags: got %b expected 0000", {dir, busy, done, aborted}); end
    done_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (done || busy) done_cnt++;
    end
    checks++; if (done_cnt !== 0) begin errors++; $display("FAIL rmid_no_done: got %0d active cycles expected 0", done_cnt); end
  endtask

  task automatic test_abort_idle();
    abort = 1'b1;
    step(3);
    abort = 1'b0;
    checks++; if (busy !== 1'b0 || aborted !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL idle_abort: busy=%b ab=%b done=%b expected 0 0 0", busy, aborted, done); end
  endtask

  initial begin
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_speed = 16'd0;
    cmd_if.cmd_ticks = 16'd0;
    cmd_if.cmd_dir   = 1'b0;
    step(1);
    test_reset();
    test_profile();
    test_saturation_abort();
    test_zero_length();
    test_low_target();
    test_back_to_back();
    test_reset_mid();
    test_abort_idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
